ps2_kbd_tx: RTL

Device-side PS/2 keyboard transmitter: the sending end of the PS/2 link that our keyboard receiver decodes. It accepts one key event (scan code plus press/release) over a valid/ready handshake and serializes it onto ps2_clk/ps2_data as 11-bit frames. A release is sent as the F0 break prefix followed by the code. It serves as the keyboard model in receiver testbenches and as a loopback source on the board.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_tx_frame.sv | 100 ++++++++++
 rtl/ps2_kbd_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keyboard transmitter:
//               top-level FSM state encoding, scan-code prefixes, frame
//               length and a helper that assembles one 11-bit frame.
// Macro       : PS2_TX_EXT_EN (consumed by ps2_kbd_tx, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  // Top-level sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;
  localparam int         FRAME_BITS   = 11;
  // Longest event: E0 F0 code
  localparam int         SEQ_MAX      = 3;

  // Frame in transmit order from bit 0: start, data LSB first, odd parity, stop
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_tx_frame.sv
// ============================================================================
// Module      : ps2_tx_frame
// Description : Serializes one byte as an 11-bit PS/2 device-to-host frame.
//               Each bit lasts 2*CLK_DIV cycles: data changes at the start of
//               the period, ps2_clk is high for the first half and low for
//               the second half.
// Ports       : clk, clrn      - clock, async active-low reset
//               start          - begin a frame with tx_byte next cycle
//               tx_byte [7:0]  - byte to send, captured on start
//               abort          - drop the frame, release lines next cycle
//               ps2_clk/data   - registered PS/2 line drivers (idle 1)
//               frame_done     - high during the final cycle of a frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_tx_frame
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 2000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       abort,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_done
);

  localparam int               CNT_W    = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PER_M1   = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PER_M2   = CNT_W'(2 * CLK_DIV - 2);
  localparam logic [3:0]       LAST_IDX = 4'(FRAME_BITS - 1);

  logic                    r_busy;
  logic [CNT_W-1:0]        r_cnt;
  logic [3:0]              r_idx;
  logic [FRAME_BITS-1:0]   w_frame;
  // Bits still to be shifted out; bit 0 is always the next one to drive
  logic [FRAME_BITS-2:0]   r_shift;

  assign w_frame = build_frame(tx_byte);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '1;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        r_busy   <= 1'b0;
        r_cnt    <= '0;
        r_idx    <= '0;
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b1;
      end else if (start) begin
        r_busy   <= 1'b1;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_shift  <= w_frame[FRAME_BITS-1:1];
        ps2_data <= w_frame[0];
        ps2_clk  <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == HALF_M1) begin
          ps2_clk <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
        end else if (r_cnt == PER_M1) begin
          r_cnt   <= '0;
          ps2_clk <= 1'b1;
          if (r_idx == LAST_IDX) begin
            // Stop bit's low phase is over: release both lines
            r_busy   <= 1'b0;
            ps2_data <= 1'b1;
          end else begin
            r_idx    <= r_idx + 1'b1;
            ps2_data <= r_shift[0];
            r_shift  <= {1'b1, r_shift[FRAME_BITS-2:1]};
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
          // Flag one cycle early so the sequencer's state change lines up
          // with the edge that releases the lines.
          if (r_idx == LAST_IDX && r_cnt == PER_M2)
            frame_done <= 1'b1;
        end
      end
    end
  end

endmodule : ps2_tx_frame

`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
// ============================================================================
// Module      : ps2_kbd_tx
// Description : Device-side PS/2 keyboard transmitter. Accepts one key event
//               over valid/ready and sends it as one or more byte frames,
//               with a BYTE_GAP idle period after every byte. Host inhibit
//               aborts the byte in flight; it is resent after inhibit drops.
// Macro       : PS2_TX_EXT_EN - adds key_ext input; E0 prefix when set.
// Ports       : clk, clrn            - clock, async active-low reset
//               req_valid/req_ready  - event handshake
//               key_code, key_break  - scan code and release flag
//               key_ext              - extended key (PS2_TX_EXT_EN only)
//               inhibit              - host inhibit, synchronous to clk
//               ps2_clk, ps2_data    - PS/2 lines, idle 1
//               done                 - one-cycle pulse at end of event
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 2000,
  parameter int BYTE_GAP = 4000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] key_code,
  input  logic       key_break,
`ifdef PS2_TX_EXT_EN
  input  logic       key_ext,
`endif
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  localparam int               GAP_W    = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);

  state_t           r_state;
  logic [7:0]       r_seq [SEQ_MAX];
  logic [1:0]       r_len;
  logic [1:0]       r_ptr;
  logic [GAP_W-1:0] r_gap;

  logic [7:0]       w_seq [SEQ_MAX];
  logic [1:0]       w_len;
  logic             w_start;
  logic             w_abort;
  logic             w_frame_done;
  logic             w_more;
  logic             w_active;

  // Byte sequence for the offered event
  always_comb begin
    w_seq[0] = key_code;
    w_seq[1] = key_code;
    w_seq[2] = key_code;
    w_len    = 2'd1;
`ifdef PS2_TX_EXT_EN
    case ({key_ext, key_break})
      2'b01: begin
        w_seq[0] = BREAK_PREFIX;
        w_len    = 2'd2;
      end
      2'b10: begin
        w_seq[0] = EXT_PREFIX;
        w_len    = 2'd2;
      end
      2'b11: begin
        w_seq[0] = EXT_PREFIX;
        w_seq[1] = BREAK_PREFIX;
        w_len    = 2'd3;
      end
      default: ;
    endcase
`else
    if (key_break) begin
      w_seq[0] = BREAK_PREFIX;
      w_len    = 2'd2;
    end
`endif
  end

  assign req_ready = (r_state == ST_IDLE) && !inhibit;
  assign w_active  = (r_state == ST_LOAD) || (r_state == ST_SHIFT) || (r_state == ST_GAP);
  assign w_abort   = inhibit && w_active;
  assign w_start   = (r_state == ST_LOAD) && !inhibit;
  // r_ptr advances when a frame completes, so it always names the next
  // byte still owed to the host (also after an abort or a gap-time inhibit).
  assign w_more    = (r_ptr != r_len);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_ptr   <= '0;
      r_gap   <= '0;
      done    <= 1'b0;
      for (int i = 0; i < SEQ_MAX; i++) r_seq[i] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && !inhibit) begin
            r_seq   <= w_seq;
            r_len   <= w_len;
            r_ptr   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_gap   <= '0;
          r_state <= inhibit ? ST_HOLD : ST_SHIFT;
        end
        ST_SHIFT: begin
          r_gap <= '0;
          if (inhibit) begin
            r_state <= ST_HOLD;
          end else if (w_frame_done) begin
            r_ptr   <= r_ptr + 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (inhibit) begin
            r_gap   <= '0;
            r_state <= ST_HOLD;
          end else if (r_gap == GAP_LAST) begin
            r_gap <= '0;
            if (w_more) begin
              r_state <= ST_LOAD;
            end else begin
              done    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_HOLD: begin
          // Gap restarts for as long as the host keeps inhibiting
          if (inhibit) begin
            r_gap <= '0;
          end else if (r_gap == GAP_LAST) begin
            r_gap <= '0;
            if (w_more) begin
              r_state <= ST_LOAD;
            end else begin
              done    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ps2_tx_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk        (clk),
    .clrn       (clrn),
    .start      (w_start),
    .tx_byte    (r_seq[r_ptr]),
    .abort      (w_abort),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .frame_done (w_frame_done)
  );

endmodule : ps2_kbd_tx

`default_nettype wire
